// File: rtl/liang_pkg.sv
// Shared types for the liang pipeline: fetch/decode/execute packets,
// micro-op fields, RV32I opcode constants and the decode-stage state.
package liang_pkg;

   // RV32I major opcodes (inst[6:0])
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
   localparam logic [6:0]  FUNCT7_ALT  = 7'h20;

   // Enum widths leave headroom so new units/ops do not change the packet layout.
   typedef enum logic [2:0] {
      FU_NONE = 3'd0,
      FU_ALU  = 3'd1,
      FU_LSU  = 3'd2
   } fu_t;

   typedef enum logic [4:0] {
      OP_NONE   = 5'd0,
      OP_LUI    = 5'd1,
      OP_AUIPC  = 5'd2,
      OP_JAL    = 5'd3,
      OP_JALR   = 5'd4,
      OP_BRANCH = 5'd5,
      OP_LOAD   = 5'd6,
      OP_STORE  = 5'd7,
      OP_ALI    = 5'd8,
      OP_ALR    = 5'd9
   } fu_op_t;

   typedef enum logic [5:0] {
      FUNC_NONE  = 6'd0,
      FUNC_ADD   = 6'd1,  FUNC_SUB   = 6'd2,  FUNC_SLL   = 6'd3,
      FUNC_SLT   = 6'd4,  FUNC_SLTU  = 6'd5,  FUNC_XOR   = 6'd6,
      FUNC_SRL   = 6'd7,  FUNC_SRA   = 6'd8,  FUNC_OR    = 6'd9,
      FUNC_AND   = 6'd10,
      FUNC_ADDI  = 6'd11, FUNC_SLTI  = 6'd12, FUNC_SLTIU = 6'd13,
      FUNC_XORI  = 6'd14, FUNC_ORI   = 6'd15, FUNC_ANDI  = 6'd16,
      FUNC_SLLI  = 6'd17, FUNC_SRLI  = 6'd18, FUNC_SRAI  = 6'd19,
      FUNC_BEQ   = 6'd20, FUNC_BNE   = 6'd21, FUNC_BLT   = 6'd22,
      FUNC_BGE   = 6'd23, FUNC_BLTU  = 6'd24, FUNC_BGEU  = 6'd25,
      FUNC_LB    = 6'd26, FUNC_LH    = 6'd27, FUNC_LW    = 6'd28,
      FUNC_LBU   = 6'd29, FUNC_LHU   = 6'd30,
      FUNC_SB    = 6'd31, FUNC_SH    = 6'd32, FUNC_SW    = 6'd33
   } fu_func_t;

   typedef enum logic [2:0] {
      LOAD_NONE = 3'd0,
      LOAD_LB   = 3'd1,
      LOAD_LH   = 3'd2,
      LOAD_LW   = 3'd3,
      LOAD_LBU  = 3'd4,
      LOAD_LHU  = 3'd5
   } load_type_t;

   typedef enum logic [2:0] {
      STORE_NONE = 3'd0,
      STORE_SB   = 3'd1,
      STORE_SH   = 3'd2,
      STORE_SW   = 3'd3
   } store_type_t;

   // Decode-stage FSM: HALT is entered once an ebreak is accepted.
   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } id_state_e;

   // 100-bit micro-op
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] imm;
      fu_t         fu;
      fu_op_t      fu_op;
      fu_func_t    fu_func;
      load_type_t  load_type;
      store_type_t store_type;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        rd_wen;
   } uop_info_t;

   // 64-bit fetch packet
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } ifToId;

   // 132-bit decode packet
   typedef struct packed {
      logic [31:0] pc;
      uop_info_t   uop_info;
   } idToEx;

endpackage

// File: rtl/id_decoder.sv
// Purely combinational RV32I decoder: instruction word + pc -> micro-op.
// Anything not recognised decodes to an all-NONE uop with illegal_o set;
// ebreak decodes to an all-NONE uop with is_ebreak_o set instead.
module id_decoder
   import liang_pkg::*;
(
   input  logic [31:0] inst_i,
   input  logic [31:0] pc_i,
   output uop_info_t   uop_o,
   output logic        illegal_o,
   output logic        is_ebreak_o
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [4:0]  rd_field;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

   assign opcode   = inst_i[6:0];
   assign funct3   = inst_i[14:12];
   assign funct7   = inst_i[31:25];
   assign rd_field = inst_i[11:7];

   assign imm_i  = {{20{inst_i[31]}}, inst_i[31:20]};
   assign imm_s  = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
   assign imm_b  = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
   assign imm_u  = {inst_i[31:12], 12'b0};
   assign imm_j  = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
   assign imm_sh = {27'b0, inst_i[24:20]};

   logic      legal;
   logic      ebreak;
   logic      wr_rd;
   logic      use_rs1;
   logic      use_rs2;
   logic      rd_wen;
   uop_info_t raw;

   // Opcode/funct classification; fields are provisional until legality is known.
   always_comb begin
      raw     = '0;
      legal   = 1'b0;
      ebreak  = 1'b0;
      wr_rd   = 1'b0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      case (opcode)
         OPC_LUI: begin
            legal = 1'b1; wr_rd = 1'b1;
            raw.fu = FU_ALU; raw.fu_op = OP_LUI; raw.imm = imm_u;
         end
         OPC_AUIPC: begin
            legal = 1'b1; wr_rd = 1'b1;
            raw.fu = FU_ALU; raw.fu_op = OP_AUIPC; raw.imm = imm_u;
         end
         OPC_JAL: begin
            legal = 1'b1; wr_rd = 1'b1;
            raw.fu = FU_ALU; raw.fu_op = OP_JAL; raw.imm = imm_j;
         end
         OPC_JALR: begin
            legal = (funct3 == 3'b000); wr_rd = 1'b1; use_rs1 = 1'b1;
            raw.fu = FU_ALU; raw.fu_op = OP_JALR; raw.imm = imm_i;
         end
         OPC_BRANCH: begin
            legal = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            raw.fu = FU_ALU; raw.fu_op = OP_BRANCH; raw.imm = imm_b;
            case (funct3)
               3'b000:  raw.fu_func = FUNC_BEQ;
               3'b001:  raw.fu_func = FUNC_BNE;
               3'b100:  raw.fu_func = FUNC_BLT;
               3'b101:  raw.fu_func = FUNC_BGE;
               3'b110:  raw.fu_func = FUNC_BLTU;
               3'b111:  raw.fu_func = FUNC_BGEU;
               default: legal = 1'b0;
            endcase
         end
         OPC_LOAD: begin
            legal = 1'b1; wr_rd = 1'b1; use_rs1 = 1'b1;
            raw.fu = FU_LSU; raw.fu_op = OP_LOAD; raw.imm = imm_i;
            case (funct3)
               3'b000:  begin raw.fu_func = FUNC_LB;  raw.load_type = LOAD_LB;  end
               3'b001:  begin raw.fu_func = FUNC_LH;  raw.load_type = LOAD_LH;  end
               3'b010:  begin raw.fu_func = FUNC_LW;  raw.load_type = LOAD_LW;  end
               3'b100:  begin raw.fu_func = FUNC_LBU; raw.load_type = LOAD_LBU; end
               3'b101:  begin raw.fu_func = FUNC_LHU; raw.load_type = LOAD_LHU; end
               default: legal = 1'b0;
            endcase
         end
         OPC_STORE: begin
            legal = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            raw.fu = FU_LSU; raw.fu_op = OP_STORE; raw.imm = imm_s;
            case (funct3)
               3'b000:  begin raw.fu_func = FUNC_SB; raw.store_type = STORE_SB; end
               3'b001:  begin raw.fu_func = FUNC_SH; raw.store_type = STORE_SH; end
               3'b010:  begin raw.fu_func = FUNC_SW; raw.store_type = STORE_SW; end
               default: legal = 1'b0;
            endcase
         end
         OPC_OP_IMM: begin
            legal = 1'b1; wr_rd = 1'b1; use_rs1 = 1'b1;
            raw.fu = FU_ALU; raw.fu_op = OP_ALI; raw.imm = imm_i;
            case (funct3)
               3'b000: raw.fu_func = FUNC_ADDI;
               3'b010: raw.fu_func = FUNC_SLTI;
               3'b011: raw.fu_func = FUNC_SLTIU;
               3'b100: raw.fu_func = FUNC_XORI;
               3'b110: raw.fu_func = FUNC_ORI;
               3'b111: raw.fu_func = FUNC_ANDI;
               3'b001: begin
                  raw.imm = imm_sh; raw.fu_func = FUNC_SLLI;
                  legal = (funct7 == 7'h00);
               end
               default: begin
                  // funct3 101: logical vs arithmetic right shift by funct7
                  raw.imm = imm_sh;
                  if (funct7 == 7'h00) raw.fu_func = FUNC_SRLI;
                  else if (funct7 == FUNCT7_ALT) raw.fu_func = FUNC_SRAI;
                  else legal = 1'b0;
               end
            endcase
         end
         OPC_OP: begin
            wr_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            raw.fu = FU_ALU; raw.fu_op = OP_ALR;
            if (funct7 == 7'h00) begin
               legal = 1'b1;
               case (funct3)
                  3'b000:  raw.fu_func = FUNC_ADD;
                  3'b001:  raw.fu_func = FUNC_SLL;
                  3'b010:  raw.fu_func = FUNC_SLT;
                  3'b011:  raw.fu_func = FUNC_SLTU;
                  3'b100:  raw.fu_func = FUNC_XOR;
                  3'b101:  raw.fu_func = FUNC_SRL;
                  3'b110:  raw.fu_func = FUNC_OR;
                  default: raw.fu_func = FUNC_AND;
               endcase
            end else if (funct7 == FUNCT7_ALT) begin
               case (funct3)
                  3'b000:  begin legal = 1'b1; raw.fu_func = FUNC_SUB; end
                  3'b101:  begin legal = 1'b1; raw.fu_func = FUNC_SRA; end
                  default: legal = 1'b0;
               endcase
            end
         end
         OPC_SYSTEM: begin
            // Only ebreak is supported; it carries no operation fields.
            ebreak = (inst_i == EBREAK_INST);
         end
         default: legal = 1'b0;
      endcase
   end

   // Final uop: register fields only where the format uses them, rd only when written.
   always_comb begin
      uop_o  = '0;
      rd_wen = legal && wr_rd && (rd_field != 5'd0);
      if (legal) begin
         uop_o        = raw;
         uop_o.rd_wen = rd_wen;
         uop_o.rd     = rd_wen  ? rd_field       : 5'd0;
         uop_o.rs1    = use_rs1 ? inst_i[19:15]  : 5'd0;
         uop_o.rs2    = use_rs2 ? inst_i[24:20]  : 5'd0;
      end
      uop_o.pc    = pc_i;
      illegal_o   = !legal && !ebreak;
      is_ebreak_o = ebreak;
   end

endmodule

// File: rtl/id_stage.sv
// Decode stage: one output register between fetch and execute, a RUN/HALT
// FSM that freezes intake after an ebreak, and flush/reset handling.
//
// Handshake: a transfer happens on a rising edge when valid and ready are
// both high in that cycle. Upstream: accept = if_valid_i && id_ready_o.
// Downstream: emit = ex_valid_o && ex_ready_i. id_ready_o never looks at
// if_valid_i, and a held uop (ex_valid_o && !ex_ready_i) keeps ex_data_o
// and illegal_o unchanged until it is emitted, flushed or reset.
module id_stage
   import liang_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         if_valid_i,
   input  logic [63:0]  if_data_i,
   output logic         id_ready_o,
   output logic         ex_valid_o,
   output logic [131:0] ex_data_o,
   input  logic         ex_ready_i,
   input  logic         flush_i,
   output logic         illegal_o,
   output logic         halted_o,
   output id_state_e    state_dbg_o
);

   ifToId     if_pkt;
   uop_info_t dec_uop;
   logic      dec_illegal;
   logic      dec_is_ebreak;

   assign if_pkt = if_data_i;

   id_decoder u_decoder (
      .inst_i      (if_pkt.inst),
      .pc_i        (if_pkt.pc),
      .uop_o       (dec_uop),
      .illegal_o   (dec_illegal),
      .is_ebreak_o (dec_is_ebreak)
   );

   id_state_e state_q, state_d;
   logic      ex_valid_q, ex_valid_d;
   idToEx     ex_data_q, ex_data_d;
   logic      illegal_q, illegal_d;
   logic      accept;
   logic      emit;

   assign accept = if_valid_i && id_ready_o;
   assign emit   = ex_valid_q && ex_ready_i;

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= RUN;
      else     state_q <= state_d;
   end

   // FSM next state: a surviving ebreak accept halts; only reset returns to RUN
   always_comb begin
      state_d = state_q;
      if ((state_q == RUN) && accept && dec_is_ebreak && !flush_i) state_d = HALT;
   end

   // FSM outputs: intake is open only in RUN with room in the output register
   always_comb begin
      id_ready_o  = (state_q == RUN) && (!ex_valid_q || ex_ready_i);
      halted_o    = (state_q == HALT);
      state_dbg_o = state_q;
   end

   // Output register next value: flush beats accept, accept beats emit
   always_comb begin
      ex_valid_d = ex_valid_q;
      ex_data_d  = ex_data_q;
      illegal_d  = illegal_q;
      if (flush_i) begin
         ex_valid_d = 1'b0;
      end else if (accept) begin
         ex_valid_d         = 1'b1;
         ex_data_d.pc       = if_pkt.pc;
         ex_data_d.uop_info = dec_uop;
         illegal_d          = dec_illegal;
      end else if (emit) begin
         ex_valid_d = 1'b0;
      end
   end

   // Output register; reset clears everything so the data is never X
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_q <= 1'b0;
         ex_data_q  <= '0;
         illegal_q  <= 1'b0;
      end else begin
         ex_valid_q <= ex_valid_d;
         ex_data_q  <= ex_data_d;
         illegal_q  <= illegal_d;
      end
   end

   assign ex_valid_o = ex_valid_q;
   assign ex_data_o  = ex_data_q;
   assign illegal_o  = ex_valid_q && illegal_q;

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL: if_valid_i  in  1  fetch packet valid.
REQ-004 SHALL: if_data_i  in  64  ifToId {pc, inst}.
REQ-005 SHALL: id_ready_o  out  1  stage can accept a packet this cycle.
REQ-006 SHALL: ex_valid_o  out  1  decoded uop valid.
REQ-007 SHALL: ex_data_o  out  132  idToEx {pc, uop_info}.
REQ-008 SHALL: ex_ready_i  in  1  execute accepts uop.
REQ-009 SHALL: flush_i  in  1  kill held uop and the incoming packet.
REQ-010 SHALL: illegal_o  out  1  held uop is an undecodable instruction, qualified by ex_valid_o.
REQ-011 SHALL: halted_o  out  1  ebreak has been accepted; stage is frozen.

Function
REQ-012 SHALL: one output register stage; accept = if_valid_i && id_ready_o; emit = ex_valid_o && ex_ready_i.
REQ-013 SHALL: id_ready_o = (state==RUN) && (!ex_valid_o || ex_ready_i), combinational, no dependency on if_valid_i.
REQ-014 SHALL: latency one cycle; a packet accepted at edge N appears on ex_data_o after edge N.
REQ-015 SHALL: while ex_valid_o && !ex_ready_i, ex_data_o and illegal_o stay bit-stable.
REQ-016 SHALL: decode RV32I opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM and OP into the matching fu_op.
REQ-017 SHALL: set fu=FU_LSU for LOAD/STORE, FU_ALU for the other legal ops, and FU_NONE for illegal.
REQ-018 SHALL: set fu_func from funct3/funct7 for ALR/ALI/BRANCH/LOAD/STORE, and FUNC_NONE otherwise.
REQ-019 SHALL: set load_type and store_type per funct3, and LOAD_NONE/STORE_NONE for other ops.
REQ-020 SHALL: build imm per I/S/B/U/J format, sign-extended to 32 bits; SLLI/SRLI/SRAI imm=shamt zero-extended; imm=0 for R-type.
REQ-021 SHALL: set rs1=inst[19:15] only for formats that read rs1 and rs2=inst[24:20] only for R/S/B, else 0.
REQ-022 SHALL: rd_wen=1 for LUI/AUIPC/JAL/JALR/LOAD/ALI/ALR with rd!=0; rd=0 when rd_wen=0.
REQ-023 SHALL: treat as illegal any undefined opcode, funct3 or funct7 (e.g. funct7 not 0x00/0x20 on OP, 0x20 on non-SUB/SRA); inst 0x00000000 is illegal; illegal decodes all-NONE with rd_wen=0.
REQ-024 SHALL: treat ebreak (0x00100073) as a valid uop with fu_op=OP_NONE, rd_wen=0 and illegal_o=0, and on accept move state RUN->HALT.
REQ-025 SHALL: in HALT, id_ready_o=0 and halted_o=1; the held ebreak still drains normally; leave HALT only by rst.
REQ-026 SHALL: flush_i clears ex_valid_o next edge and discards a same-cycle accept; flush dominates accept and emit.
REQ-027 SHALL: flush_i in HALT clears valid but does not leave HALT.
REQ-028 SHALL: copy uop_info.pc and idToEx.pc from if_data_i.pc.

Reset
REQ-029 SHALL: on rst, next edge gives ex_valid_o=0, illegal_o=0, halted_o=0 and state=RUN.
REQ-030 SHALL: zero ex_data_o on rst; it is don't-care when invalid but must not be X.
REQ-031 SHALL: rst dominate flush_i and accept, including mid-backpressure.

Structure
REQ-032 SHALL: take ifToId, idToEx, uop_info_t and all enums from liang_pkg.
REQ-033 SHALL: add new opcode constants and the RUN/HALT state enum to liang_pkg.
REQ-034 SHALL: use one combinational sub-module, id_decoder (inst, pc -> uop_info_t, illegal, is_ebreak); id_stage holds the register, handshake and FSM.

Verification
REQ-035 SHALL: inst 0x00500093 pc 0x80000000, ex_ready=1 -> next cycle fu_op ALI, fu_func ADDI, rd 1, rd_wen 1, rs1 0, imm 0x5.
REQ-036 SHALL: inst 0xFFC0A103 -> fu FU_LSU, LOAD, LW, LOAD_LW, rs1 1, rd 2, imm 0xFFFFFFFC.
REQ-037 SHALL: hold ex_ready=0 for 3 cycles with if_valid=1 -> id_ready_o=0 and ex_data_o stable; on release, exactly one uop per cycle with none dropped or duplicated.
REQ-038 SHALL: flush_i with simultaneous accept and a held uop -> ex_valid_o=0 next cycle.
REQ-039 SHALL: inst 0x00000000 -> illegal_o=1, fu FU_NONE, rd_wen 0; inst 0x00100073 -> after emit, halted_o=1 and id_ready_o=0 until rst.
